// File: rtl/threshold_alarm_fsm.sv
// threshold_alarm_fsm
// Converts per-sample magnitude-comparator results (e/l/g of sample vs
// threshold) into a debounced alarm level with hysteresis: PERSIST
// consecutive "above" samples raise the alarm, and RELEASE consecutive
// "not above" samples drop it. Samples where en or in_valid is low are
// ignored without breaking a run. The block also counts alarm assertions
// with saturation and keeps a sticky flag for illegal e/l/g codes.
//
// Handshake: a sample is consumed in every cycle where en & in_valid is
// high. There is no back-pressure. Outputs are registered, so alarm and
// the pulses reflect a qualifying sample in the cycle after it is taken.
module threshold_alarm_fsm #(
    parameter int PERSIST = 3,
    parameter int RELEASE = 2,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       in_valid,
    input  logic       in_e,
    input  logic       in_l,
    input  logic       in_g,
    output logic       alarm,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       err,
    output logic [7:0] event_cnt,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_ARM   = 2'd1,
        ST_ALARM = 2'd2,
        ST_REL   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PERSIST_C = CNT_W'(PERSIST);
    localparam logic [CNT_W-1:0] RELEASE_C = CNT_W'(RELEASE);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             rise_nxt;
    logic             fall_nxt;

    logic sample;
    logic legal;
    logic take;
    logic bad;
    logic above;

    // Sample qualification: a sample is legal only when exactly one of
    // e/l/g is set; illegal samples only touch the sticky error flag.
    always_comb begin
        sample  = en & in_valid;
        legal   = ({in_e, in_l, in_g} == 3'b100) ||
                  ({in_e, in_l, in_g} == 3'b010) ||
                  ({in_e, in_l, in_g} == 3'b001);
        take    = sample & legal;
        bad     = sample & ~legal;
        above   = in_g;
        cnt_inc = cnt + CNT_ONE;
    end

    // State register plus registered pulses, error flag and event counter.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state      <= ST_CLEAR;
            cnt        <= '0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            err        <= 1'b0;
            event_cnt  <= 8'h00;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
            if (bad) begin
                err <= 1'b1;
            end
            if (rise_nxt && (event_cnt != 8'hFF)) begin
                event_cnt <= event_cnt + 8'h01;
            end
        end
    end

    // Next-state logic: only legal taken samples move the FSM or the run
    // counter; everything else holds.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (take) begin
            unique case (state)
                ST_CLEAR: begin
                    if (above) begin
                        cnt_nxt = CNT_ONE;
                        if (PERSIST == 1) begin
                            state_nxt = ST_ALARM;
                            rise_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_ARM;
                        end
                    end
                end
                ST_ARM: begin
                    if (above) begin
                        if (cnt_inc == PERSIST_C) begin
                            state_nxt = ST_ALARM;
                            cnt_nxt   = '0;
                            rise_nxt  = 1'b1;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        state_nxt = ST_CLEAR;
                        cnt_nxt   = '0;
                    end
                end
                ST_ALARM: begin
                    if (!above) begin
                        cnt_nxt = CNT_ONE;
                        if (RELEASE == 1) begin
                            state_nxt = ST_CLEAR;
                            fall_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_REL;
                        end
                    end
                end
                ST_REL: begin
                    if (!above) begin
                        if (cnt_inc == RELEASE_C) begin
                            state_nxt = ST_CLEAR;
                            cnt_nxt   = '0;
                            fall_nxt  = 1'b1;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        state_nxt = ST_ALARM;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output decode: the alarm stays up through the release window.
    always_comb begin
        alarm     = (state == ST_ALARM) || (state == ST_REL);
        state_dbg = state;
    end

endmodule

// File: tb/tb_threshold_alarm_fsm.sv
// tb_threshold_alarm_fsm
// Directed scenarios followed by randomized traffic. A behavioural model
// tracks the alarm level and the current run length; each driven cycle
// pushes the expected output vector, and a monitor pops and compares it
// one cycle later.
module tb_threshold_alarm_fsm;

    localparam int PERSIST = 3;
    localparam int RELEASE = 2;
    localparam int CNT_W   = 4;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       in_valid;
    logic       in_e;
    logic       in_l;
    logic       in_g;
    logic       alarm;
    logic       rise_pulse;
    logic       fall_pulse;
    logic       err;
    logic [7:0] event_cnt;
    logic [1:0] state_dbg;

    threshold_alarm_fsm #(
        .PERSIST(PERSIST),
        .RELEASE(RELEASE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_e      (in_e),
        .in_l      (in_l),
        .in_g      (in_g),
        .alarm     (alarm),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .err       (err),
        .event_cnt (event_cnt),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_e     = 1'b0;
        in_l     = 1'b0;
        in_g     = 1'b0;
    end

    // ---------------- scoreboard state ----------------
    // Expected vector layout: {alarm, rise, fall, err, event_cnt[7:0]}
    logic [11:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Behavioural model: alarm level, length of the current qualifying run
    bit m_alarm = 1'b0;
    bit m_err   = 1'b0;
    int m_run   = 0;
    int m_evt   = 0;

    task automatic model_step(input bit r, input bit c, input bit e_n,
                              input bit v, input bit e, input bit l,
                              input bit g);
        bit rise;
        bit fall;
        int ones;
        rise = 1'b0;
        fall = 1'b0;
        if (r || c) begin
            m_alarm = 1'b0;
            m_err   = 1'b0;
            m_run   = 0;
            m_evt   = 0;
        end else if (e_n && v) begin
            ones = int'(e) + int'(l) + int'(g);
            if (ones != 1) begin
                m_err = 1'b1;
            end else if (!m_alarm) begin
                if (g) begin
                    m_run++;
                    if (m_run == PERSIST) begin
                        m_alarm = 1'b1;
                        m_run   = 0;
                        rise    = 1'b1;
                        if (m_evt < 255) m_evt++;
                    end
                end else begin
                    m_run = 0;
                end
            end else begin
                if (!g) begin
                    m_run++;
                    if (m_run == RELEASE) begin
                        m_alarm = 1'b0;
                        m_run   = 0;
                        fall    = 1'b1;
                    end
                end else begin
                    m_run = 0;
                end
            end
        end
        exp_q.push_back({m_alarm, rise, fall, m_err, 8'(m_evt)});
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit r, input bit c, input bit e_n,
                         input bit v, input bit e, input bit l,
                         input bit g);
        @(negedge clk);
        rst      = r;
        clr      = c;
        en       = e_n;
        in_valid = v;
        in_e     = e;
        in_l     = l;
        in_g     = g;
        model_step(r, c, e_n, v, e, l, g);
    endtask

    task automatic smp_g();  drive(0, 0, 1, 1, 0, 0, 1); endtask
    task automatic smp_l();  drive(0, 0, 1, 1, 0, 1, 0); endtask
    task automatic smp_e();  drive(0, 0, 1, 1, 1, 0, 0); endtask
    task automatic do_rst(); drive(1, 0, 1, 1, 0, 0, 1); endtask
    task automatic do_clr(); drive(0, 1, 1, 1, 0, 0, 1); endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [11:0] exp_v;
        logic [11:0] act_v;
        #1;
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {alarm, rise_pulse, fall_pulse, err, event_cnt};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL out_vec t=%0t: actual alarm=%b rise=%b fall=%b err=%b evt=%0d required alarm=%b rise=%b fall=%b err=%b evt=%0d",
                         $time, act_v[11], act_v[10], act_v[9], act_v[8], act_v[7:0],
                         exp_v[11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit r, c, e_n, v, e, l, g;
        int sel;

        // Reset held, then scenario 1: reset mid-ARM restarts the run
        do_rst();
        do_rst();
        smp_g(); smp_g();
        do_rst(); do_rst();
        smp_g(); smp_g(); smp_g();
        smp_l(); smp_l();

        // Scenario 2: g,g,g raises; g,g,l does not
        smp_g(); smp_g(); smp_g();
        smp_l(); smp_l();
        smp_g(); smp_g(); smp_l();

        // Scenario 3: release with l,e; interrupted release l,g,l
        smp_g(); smp_g(); smp_g();
        smp_l(); smp_e();
        smp_g(); smp_g(); smp_g();
        smp_l(); smp_g(); smp_l();
        smp_l(); smp_l();

        // Scenario 4: illegal code while alarmed, then soft clear
        smp_g(); smp_g(); smp_g();
        drive(0, 0, 1, 1, 1, 0, 1);
        drive(0, 0, 1, 1, 0, 0, 0);
        do_clr();
        smp_e();

        // Scenario 5: gaps from in_valid=0 and en=0 do not break the run
        smp_g();
        repeat (3) drive(0, 0, 1, 0, 0, 0, 1);
        smp_g();
        repeat (2) drive(0, 0, 0, 1, 0, 0, 1);
        smp_g();
        drive(0, 0, 0, 1, 0, 1, 0);
        smp_l(); smp_l();

        // Scenario 6: saturating event counter
        do_clr();
        for (int i = 0; i < 260; i++) begin
            smp_g(); smp_g(); smp_g();
            smp_l(); smp_l();
        end
        drain();
        n_tests++;
        if (event_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL evt_saturate: actual=%0d required=255", event_cnt);
        end

        // Randomized traffic
        do_clr();
        for (int i = 0; i < 2500; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            c   = ($urandom_range(0, 199) == 0);
            e_n = ($urandom_range(0, 9) != 0);
            v   = ($urandom_range(0, 4) != 0);
            sel = $urandom_range(0, 19);
            if (sel < 11) begin
                {e, l, g} = 3'b001;
            end else if (sel < 15) begin
                {e, l, g} = 3'b010;
            end else if (sel < 19) begin
                {e, l, g} = 3'b100;
            end else begin
                {e, l, g} = 3'($urandom_range(0, 7));
            end
            drive(r, c, e_n, v, e, l, g);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
